sseg_scan_ctrl: RTL and testbench

//   Refresh/scan controller for the 4-digit multiplexed 7-segment display.

---
 rtl/sseg_pkg.sv | 18 +
 rtl/sseg_scan_ctrl_if.sv | 25 ++
 rtl/sseg_prescaler.sv | 41 ++++
 rtl/sseg_scan_ctrl.sv | 72 +++++++
 tb/tb_sseg_scan_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  typedef logic [NUM_DIGITS-1:0] digit_vec_t;
  typedef logic [IDX_W-1:0]      digit_idx_t;

  // Anodes are active low, so all-ones means every digit dark.
  localparam digit_vec_t ANODE_OFF = 4'b1111;

  // One-cold select for a digit index: 0 -> 1110, 3 -> 0111.
  function automatic digit_vec_t one_cold(input digit_idx_t idx);
    return ~(digit_vec_t'(1) << idx);
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Control/display bundle between the scan controller and its user.
// master drives enable and masks; slave (the controller) drives the display side.
interface sseg_scan_ctrl_if;
  import sseg_pkg::*;

  logic       en;
  digit_vec_t blank_mask;
  digit_vec_t dp_mask;
  digit_vec_t sel;
  digit_vec_t an;
  logic       dp;
  digit_idx_t digit_idx;
  logic       slot_tick;

  modport master (
    output en, blank_mask, dp_mask,
    input  sel, an, dp, digit_idx, slot_tick
  );

  modport slave (
    input  en, blank_mask, dp_mask,
    output sel, an, dp, digit_idx, slot_tick
  );

endinterface

// File: rtl/sseg_prescaler.sv
// Slot prescaler: counts 0..PRESCALE-1 while enabled and flags the wrap.
// Exposes the next-state count so the owner can register outputs that line
// up with the count that will be live in the following cycle.
module sseg_prescaler #(
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  // Next count: hold when disabled, wrap to 0 at the end of the slot.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (en_i) begin
      if (cnt_q == CNT_W'(PRESCALE - 1)) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_d_o = cnt_d;
  assign wrap_o  = wrap;

endmodule

// File: rtl/sseg_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller.
// Rotates a one-cold digit select, gates the anodes with a dead-time blank at
// the start of each slot plus per-digit blanking, and drives the decimal point.
// Every output is registered from next-state values so sel/an/dp/digit_idx
// always describe the same digit and the same prescaler count.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter  int PRESCALE = 100000,
  parameter  int DEAD     = 1000,
  localparam int CNT_W    = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst,
  sseg_scan_ctrl_if.slave  bus
);

  logic [CNT_W-1:0] cnt_d;
  logic             wrap;

  digit_idx_t digit_q, digit_d;
  digit_vec_t sel_q, sel_d;
  digit_vec_t an_q, an_d;
  logic       dp_q, dp_d;
  logic       tick_q;
  logic       dark;

  sseg_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en_i    (bus.en),
    .cnt_d_o (cnt_d),
    .wrap_o  (wrap)
  );

  // Next digit, select and gated anode/dp drive, all from next-state count.
  always_comb begin
    digit_d = digit_q + digit_idx_t'(wrap);
    sel_d   = one_cold(digit_d);
    // Dark while frozen, during the anti-ghosting window, or when masked.
    dark    = !bus.en || (int'(cnt_d) < DEAD) || bus.blank_mask[digit_d];
    an_d    = dark ? ANODE_OFF : sel_d;
    dp_d    = !((an_d != ANODE_OFF) && bus.dp_mask[digit_d]);
  end

  // Output and digit registers; reset leaves the display dark on digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
      sel_q   <= one_cold('0);
      an_q    <= ANODE_OFF;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      digit_q <= digit_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      tick_q  <= wrap;
    end
  end

  assign bus.digit_idx = digit_q;
  assign bus.sel       = sel_q;
  assign bus.an        = an_q;
  assign bus.dp        = dp_q;
  assign bus.slot_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: PRESCALE=8/DEAD=2 main instance with a scoreboard
// fed by a flat slot-position model, plus a DEAD=0 instance.
module tb_sseg_scan_ctrl;

  localparam int P  = 8;
  localparam int DT = 2;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] an;
    logic       dp;
    logic [1:0] idx;
    logic       tick;
  } obs_t;

  logic clk = 1'b0;
  logic rst;

  sseg_scan_ctrl_if bif ();
  sseg_scan_ctrl_if bif0 ();

  sseg_scan_ctrl #(.PRESCALE(P), .DEAD(DT)) u_dut  (.clk(clk), .rst(rst), .bus(bif));
  sseg_scan_ctrl #(.PRESCALE(P), .DEAD(0))  u_dut0 (.clk(clk), .rst(rst), .bus(bif0));

  always #5 clk = ~clk;

  obs_t sb[$];
  int   m_pos;
  int   ncmp;
  int   nfail;

  function automatic obs_t observe();
    obs_t o;
    o.sel  = bif.sel;
    o.an   = bif.an;
    o.dp   = bif.dp;
    o.idx  = bif.digit_idx;
    o.tick = bif.slot_tick;
    return o;
  endfunction

  // Advance one clock; the model predicts what the DUT will show afterwards.
  task automatic step();
    obs_t       e;
    int         cnt, dig;
    logic [3:0] s;
    @(posedge clk);
    if (bif.en) m_pos = (m_pos + 1) % (4 * P);
    cnt    = m_pos % P;
    dig    = m_pos / P;
    s      = 4'b0001 << dig;
    e.sel  = ~s;
    e.idx  = 2'(dig);
    e.tick = bif.en && (cnt == 0);
    e.an   = (!bif.en || cnt < DT || bif.blank_mask[dig]) ? 4'b1111 : e.sel;
    e.dp   = !((e.an != 4'b1111) && bif.dp_mask[dig]);
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    obs_t rv;
    rv = '{sel: 4'b1110, an: 4'b1111, dp: 1'b1, idx: 2'd0, tick: 1'b0};
    rst = 1'b1; bif.en = 1'b1; bif.blank_mask = '0; bif.dp_mask = '0; m_pos = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    o = observe(); ncmp++;
    if (o !== rv) begin nfail++; $display("FAIL reset_vals got %b want %b", o, rv); end
    for (int i = 0; i < 21; i++) begin
      step(); e = sb.pop_front(); o = observe(); ncmp++;
      if (o !== e) begin nfail++; $display("FAIL reset_run c%0d got %b want %b", i, o, e); end
      if (i < 1) begin
        ncmp++;
        if (o.an !== 4'b1111) begin nfail++; $display("FAIL reset_dead c%0d got %b want 1111", i, o.an); end
      end
    end
    // Now at cnt=5 of digit 2: reset asynchronously mid-cycle.
    #2 rst = 1'b1; m_pos = 0;
    #1 o = observe(); ncmp++;
    if (o !== rv) begin nfail++; $display("FAIL reset_async got %b want %b", o, rv); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); e = sb.pop_front(); o = observe(); ncmp++;
      if (o !== e) begin nfail++; $display("FAIL reset_post c%0d got %b want %b", i, o, e); end
      ncmp++;
      if ((o.an === 4'b1111) !== (i < 1)) begin
        nfail++; $display("FAIL reset_post_dead c%0d got an=%b", i, o.an);
      end
    end
  endtask

  task automatic test_scan();
    obs_t o, e;
    int   ticks = 0;
    logic [3:0] prev_sel;
    prev_sel = bif.sel;
    for (int i = 0; i < 40; i++) begin
      step(); e = sb.pop_front(); o = observe(); ncmp++;
      if (o !== e) begin nfail++; $display("FAIL scan c%0d got %b want %b", i, o, e); end
      ncmp++;
      if ((o.sel !== prev_sel) !== (o.tick === 1'b1)) begin
        nfail++; $display("FAIL scan_align c%0d got sel %b->%b tick=%b", i, prev_sel, o.sel, o.tick);
      end
      if (o.tick === 1'b1) ticks++;
      prev_sel = o.sel;
    end
    ncmp++;
    if (ticks != 5) begin nfail++; $display("FAIL scan_ticks got %0d want 5", ticks); end
  endtask

  task automatic test_blank();
    obs_t o, e;
    bif.blank_mask = 4'b0100;
    for (int i = 0; i < 34; i++) begin
      step(); e = sb.pop_front(); o = observe(); ncmp++;
      if (o !== e) begin nfail++; $display("FAIL blank c%0d got %b want %b", i, o, e); end
      if (o.sel === 4'b1011) begin
        ncmp++;
        if (o.an !== 4'b1111 || o.dp !== 1'b1) begin
          nfail++; $display("FAIL blank_slot c%0d got an=%b dp=%b want 1111/1", i, o.an, o.dp);
        end
      end
    end
    bif.blank_mask = '0;
  endtask

  task automatic test_dp();
    obs_t o, e;
    bif.dp_mask = 4'b0001;
    step(); void'(sb.pop_front());
    for (int i = 0; i < 34; i++) begin
      step(); e = sb.pop_front(); o = observe(); ncmp++;
      if (o !== e) begin nfail++; $display("FAIL dp c%0d got %b want %b", i, o, e); end
      ncmp++;
      if ((o.dp === 1'b0) !== (o.an === 4'b1110)) begin
        nfail++; $display("FAIL dp_gate c%0d got dp=%b an=%b", i, o.dp, o.an);
      end
    end
    bif.dp_mask = '0;
  endtask

  task automatic test_enable();
    obs_t o, e;
    int   guard = 0;
    while (m_pos != P + 4 && guard < 64) begin
      step(); e = sb.pop_front(); o = observe(); ncmp++;
      if (o !== e) begin nfail++; $display("FAIL en_pre c%0d got %b want %b", guard, o, e); end
      guard++;
    end
    ncmp++;
    if (m_pos != P + 4) begin nfail++; $display("FAIL en_reach got pos %0d want %0d", m_pos, P + 4); end
    bif.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); e = sb.pop_front(); o = observe(); ncmp++;
      if (o !== e) begin nfail++; $display("FAIL en_off c%0d got %b want %b", i, o, e); end
      ncmp++;
      if (o.an !== 4'b1111 || o.sel !== 4'b1101 || o.tick !== 1'b0) begin
        nfail++; $display("FAIL en_hold c%0d got an=%b sel=%b tick=%b", i, o.an, o.sel, o.tick);
      end
    end
    bif.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(); e = sb.pop_front(); o = observe(); ncmp++;
      if (o !== e) begin nfail++; $display("FAIL en_on c%0d got %b want %b", i, o, e); end
      if (i == 3) begin
        ncmp++;
        if (o.sel !== 4'b1011 || o.tick !== 1'b1) begin
          nfail++; $display("FAIL en_resume got sel=%b tick=%b want 1011/1", o.sel, o.tick);
        end
      end
    end
  endtask

  task automatic test_dead0();
    obs_t o, e;
    logic [3:0] s;
    rst = 1'b1; m_pos = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(); e = sb.pop_front(); o = observe(); ncmp++;
      if (o !== e) begin nfail++; $display("FAIL dead0_main c%0d got %b want %b", i, o, e); end
      s = 4'b0001 << (((i + 1) / P) % 4);
      ncmp++;
      if (bif0.sel !== ~s || bif0.an !== bif0.sel || bif0.an === 4'b1111) begin
        nfail++; $display("FAIL dead0 c%0d got sel=%b an=%b want %b", i, bif0.sel, bif0.an, ~s);
      end
    end
  endtask

  initial begin
    ncmp = 0; nfail = 0;
    bif0.en = 1'b1; bif0.blank_mask = '0; bif0.dp_mask = '0;
    test_reset();
    test_scan();
    test_blank();
    test_dp();
    test_enable();
    test_dead0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
